pc_seq_unit: RTL
================

// Module: pc_seq_unit
// PURPOSE
//  Parametrised program-counter sequencer; successor to the PC/nextPC pair.
//  - Holds the fetch address.
//  - Adds stall, PC-relative or absolute branching, call/return through an internal
//    return-address stack (RAS), and halt/done.
//  - Sits between the control decoder and instruction ROM; prog_ctr_out drives ROM address.
// PARAMETERS
//  D          12  PC / address width in bits
//  RAS_DEPTH   4  return-address stack entries (>=1)
//  OFF_W       8  width of signed relative branch offset (OFF_W <= D)
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          synchronous, active-high reset
//  start          in   1          load start_address, clear RAS/flags, enter RUN
//  start_address  in   D          restart address
//  stall          in   1          hold PC this cycle (RUN only)
//  branch         in   1          current instruction is a branch
//  taken          in   1          branch condition true (used only with branch)
//  rel_mode       in   1          1: target = PC + sext(offset); 0: absolute target
//  target         in   D          absolute branch/call target
//  offset         in   OFF_W      signed relative branch offset
//  call           in   1          push PC+1, jump to target (always absolute)
//  ret            in   1          pop RAS, jump to popped address
//  halt           in   1          stop sequencing
//  prog_ctr_out   out  D          current PC (registered)
//  done           out  1          1 while in HALTED
//  ras_count      out  $clog2(RAS_DEPTH+1)  valid RAS entries
//  ras_overflow   out  1          sticky: call while RAS full
//  ras_underflow  out  1          sticky: ret while RAS empty
// BEHAVIOUR
//  - States: IDLE (post-reset, PC held), RUN, HALTED.
//  - Reset (clk edge, reset=1): prog_ctr_out=0, state=IDLE, done=0, ras_count=0;
//    both flags=0; RAS contents don't-care. Overrides all other inputs, incl. mid-call.
//  - All inputs sampled at rising clk. PC/state update that edge (1-cycle latency).
//  - Priority per edge: reset > start > halt > stall > ret > call > branch&taken > +1.
//  - start (any state): PC=start_address, ras_count=0, flags=0, state=RUN.
//  - IDLE/HALTED without start: PC holds; all other controls ignored.
//  - RUN, halt=1: PC holds, state=HALTED, done=1 from next cycle.
//  - RUN, stall=1: PC, RAS and flags unchanged.
//  - RUN, ret=1:
//    - RAS non-empty: PC=top, ras_count-1.
//    - RAS empty: PC=PC+1, ras_underflow=1.
//    - call on the same cycle is ignored.
//  - RUN, call=1:
//    - RAS not full: push (PC+1) mod 2^D, ras_count+1, PC=target.
//    - RAS full: no push, count unchanged, ras_overflow=1, PC=target still.
//  - RUN, branch=1 & taken=1:
//    - rel_mode=0: PC=target.
//    - rel_mode=1: PC = (PC + sign-extend(offset)) mod 2^D.
//  - branch=1, taken=0, or taken=1, branch=0: PC=PC+1 (no branch).
//  - Increment/relative arithmetic in D bits; wraps 2^D-1 -> 0 silently.
//  - Flags stay set until reset or start. done clears on start/reset.
// TESTING
//  1) reset; start=1, start_address=0; 4 idle cycles -> PC 0,1,2,3,4; done=0.
//  2) PC=5: branch=1,taken=0 -> 6; branch=1,taken=1,rel_mode=0,target=16 -> 16;
//     rel_mode=1, offset=-3 -> 13.
//  3) PC=20: call target=40 -> PC=40, count=1; stall 2 cycles -> PC=40 held;
//     ret -> PC=21, count=0; ret again -> PC=22, ras_underflow=1.
//  4) RAS_DEPTH=4: 5 nested calls -> count=4, ras_overflow=1, PC=5th target;
//     4 rets -> pushed addresses popped in LIFO order.
//  5) D=12, PC=4095, no control -> PC=0; rel offset +1 at 4095 -> 0.
//  6) halt at PC=9 -> PC holds 9, done=1 for 3 cycles, branch ignored;
//     start, start_address=128 -> PC=128, done=0;
//     reset mid-call -> PC=0, IDLE, count=0.

Source files
------------

// File: rtl/pc_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_unit
//  Purpose  : Program-counter sequencer. Holds the fetch address and
//             advances it by +1, stall, PC-relative or absolute branch,
//             call/return through an internal return-address stack (RAS),
//             and halt/done.
//  Ports    : clk, reset (sync, active-high)
//             start/start_address  - restart sequencing at an address
//             stall, branch, taken, rel_mode, target, offset,
//             call, ret, halt      - per-cycle control from the decoder
//             prog_ctr_out         - registered PC, drives ROM address
//             done                 - high while halted
//             ras_count            - number of valid RAS entries
//             ras_overflow/underflow - sticky stack error flags
//  Revision : 1.0  initial release
// ============================================================================
module pc_seq_unit #(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4,
  parameter int OFF_W     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [D-1:0]                     start_address,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             taken,
  input  logic                             rel_mode,
  input  logic [D-1:0]                     target,
  input  logic [OFF_W-1:0]                 offset,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             halt,
  output logic [D-1:0]                     prog_ctr_out,
  output logic                             done,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  // Stack index width; a one-entry stack still needs a 1-bit index.
  localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state;
  logic [D-1:0]  pc;
  logic [CW-1:0] count;
  logic          ovf;
  logic          unf;
  logic [D-1:0]  stack [RAS_DEPTH];

  logic [D-1:0]  pc_inc;
  logic [D-1:0]  off_ext;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;

  assign pc_inc   = pc + D'(1);
  // Signed size cast sign-extends the offset to the full PC width.
  assign off_ext  = D'($signed(offset));
  assign top_idx  = IW'(count - CW'(1));
  assign push_idx = IW'(count);

  // Priority inside RUN: halt > stall > ret > call > taken branch > +1.
  // start and reset act in every state; IDLE/HALTED otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (start) begin
      state <= ST_RUN;
      pc    <= start_address;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (state == ST_RUN) begin
      if (halt) begin
        state <= ST_HALTED;
      end else if (stall) begin
        // hold everything
      end else if (ret) begin
        if (count != '0) begin
          pc    <= stack[top_idx];
          count <= count - CW'(1);
        end else begin
          pc  <= pc_inc;
          unf <= 1'b1;
        end
      end else if (call) begin
        // The jump happens even when the return address cannot be saved.
        if (count != FULL) begin
          stack[push_idx] <= pc_inc;
          count           <= count + CW'(1);
        end else begin
          ovf <= 1'b1;
        end
        pc <= target;
      end else if (branch && taken) begin
        pc <= rel_mode ? (pc + off_ext) : target;
      end else begin
        pc <= pc_inc;
      end
    end
  end

  assign prog_ctr_out  = pc;
  assign done          = (state == ST_HALTED);
  assign ras_count     = count;
  assign ras_overflow  = ovf;
  assign ras_underflow = unf;

endmodule
`default_nettype wire
